filter_peak_detector: RTL and testbench
=======================================

Name: filter_peak_detector

Overview:
- Consumes the shaped filter output (one FilterVn `output_data` stream, `SIZE_FILTER_DATA` bits, one sample per clk) directly downstream of the filter top level.
- Detects threshold-crossing pulses and measures peak amplitude, peak timestamp and pulse width.
- Emits one event record per pulse through a single-entry valid/ready output buffer to the readout logic.

Parameters:
- DATA_W, SIZE_FILTER_DATA (package), width of the signed input sample and of the amplitude.
- TS_W, 32, width of the free-running timestamp counter.
- WIDTH_W, 8, width of the pulse-width counter.
- MAX_WIDTH, 255, pulse length (in samples) at which the event is forced out as truncated. Must be ≤ 2^WIDTH_W-1.
- LOST_W, 16, width of the dropped-event counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- input_data  in  DATA_W  signed two's-complement filter sample, new value every clk.
- threshold  in  DATA_W  signed trigger level; quasi-static, sampled every clk.
- event_valid  out  1  event record available.
- event_ready  in  1  consumer accepts the record when event_valid&&event_ready.
- event_amp  out  DATA_W  signed peak sample value.
- event_time  out  TS_W  timestamp of the peak sample.
- event_width  out  WIDTH_W  number of samples with input_data > threshold.
- event_truncated  out  1  pulse hit MAX_WIDTH.
- event_pileup  out  1  second maximum seen inside the pulse (0 unless feature enabled).
- lost_count  out  LOST_W  saturating count of events dropped for lack of buffer space.

Behaviour:
- Async reset, all outputs 0:
  - event_valid=0, event_amp/time/width=0, event_truncated=0, event_pileup=0, lost_count=0.
  - ts counter=0, FSM=IDLE.
  - A reset mid-pulse discards the pulse; no event is emitted after reset release.
- ts counter increments every clk and wraps 2^TS_W-1 -> 0 with no flag.
- All comparisons are signed. "Above" means input_data > threshold (strict).
- FSM states IDLE, PULSE, WAIT_LOW:
  - IDLE: when the sample is above threshold -> PULSE.
    - max<=sample, peak_ts<=ts, width<=1, pileup<=0.
  - PULSE, sample above:
    - width+1.
    - If sample > max (strict; ties keep the first occurrence): max<=sample, peak_ts<=ts.
    - If the updated width reaches MAX_WIDTH: emit with truncated=1 -> WAIT_LOW.
  - PULSE, sample not above: emit with truncated=0 -> IDLE. The terminating sample is not counted in width.
  - WAIT_LOW: ignore samples until one is not above, then -> IDLE. No event is emitted for the tail.
- Emit:
  - The buffer is free if event_valid==0, or if event_valid&&event_ready in the same cycle.
  - Free: load the record and set event_valid=1 at that edge. The record is visible the cycle after the terminating sample edge (latency 1).
  - Not free: drop the record and increment lost_count, saturating at all-ones.
- event_valid stays high with a stable record until the handshake.
  - Handshake with no simultaneous emit: event_valid falls next edge.
  - Handshake with a simultaneous emit: back-to-back, event_valid stays 1 and the record updates.
- A pulse may restart in IDLE on the sample immediately after emission; back-to-back pulses are separated by at least one sample not above threshold.

Optional Feature:
- Macro FILTER_PEAK_DETECTOR_PILEUP_EN, PILEUP_HYST parameter (default 16).
- Defined:
  - In PULSE, track a "fell" flag, set when sample < max-PILEUP_HYST (computed in DATA_W+1 bits, no wrap).
  - If "fell" is set and the sample then rises above the previous sample, set the pileup bit.
  - The pileup bit is carried to event_pileup.
- Undefined: no pileup logic is generated; event_pileup is tied 0.

Decomposition:
- Into package_settings:
  - SIZE_TIMESTAMP(32), SIZE_PULSE_WIDTH(8), SIZE_LOST_CNT(16).
  - typedef enum logic[1:0] {PD_IDLE, PD_PULSE, PD_WAIT_LOW} pd_state_t.
  - typedef struct packed {amp, time, width, truncated, pileup} pd_event_t.
- Sub-module pd_event_buffer: single-entry valid/ready register plus saturating lost counter, instantiated once.

Test Plan:
- Basic pulse: threshold=100, input 0,50,150,300,200,80,0 (300 at ts=10) -> one event, amp=300, time=10, width=3, truncated=0, valid the cycle after sample 80.
- Plateau tie: threshold=100, input 0,200,250,250,0 -> amp=250, time of the first 250, width=3.
- Truncation: MAX_WIDTH=4, threshold=0, input 10 for 7 cycles then 0 -> one event, width=4, truncated=1; no further event, FSM back in IDLE after the 0.
- Backpressure: event_ready=0, three pulses -> first record held unchanged, lost_count=2; assert ready -> valid drops. Second case: ready=1 coinciding with the next emit -> valid stays high with the new record.
- Reset mid-pulse: assert reset during the 300 sample of the basic pulse, release, then hold input at 0 -> no event, all outputs 0, ts restarts at 0.
- Pileup (macro on, HYST=16): input 0,200,150,180,50 with threshold=100 -> event_pileup=1, amp=200. Same stimulus with the macro off -> event_pileup=0.

Source files
------------

// File: rtl/package_settings.sv
//==============================================================================
// Module      : package_settings
// Description : Shared widths, FSM state encoding and event record layout for
//               the filter peak detector.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package package_settings;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int SIZE_TIMESTAMP   = 32;
    localparam int SIZE_PULSE_WIDTH = 8;
    localparam int SIZE_LOST_CNT    = 16;

    typedef enum logic [1:0] {
        PD_IDLE     = 2'd0,
        PD_PULSE    = 2'd1,
        PD_WAIT_LOW = 2'd2
    } pd_state_t;

    // Event record as seen by the readout logic (field order = bit order,
    // amplitude in the MSBs).
    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amp;
        logic [SIZE_TIMESTAMP-1:0]          peak_time;
        logic [SIZE_PULSE_WIDTH-1:0]        width;
        logic                               truncated;
        logic                               pileup;
    } pd_event_t;

endpackage

`default_nettype wire

// File: rtl/filter_peak_detector_event_buffer.sv
//==============================================================================
// Module      : pd_event_buffer
// Description : Single-entry valid/ready output register for event records,
//               with a saturating counter of records dropped while full.
// Ports       : clk, reset      - clock, async active-high reset
//               push, push_rec  - new record offered this cycle
//               ready           - consumer accepts the held record
//               valid, rec      - held record and its valid flag
//               lost_count      - saturating count of dropped records
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pd_event_buffer #(
    parameter int REC_W  = 58,
    parameter int LOST_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [REC_W-1:0]  push_rec,
    input  logic              ready,
    output logic              valid,
    output logic [REC_W-1:0]  rec,
    output logic [LOST_W-1:0] lost_count
);

    // The slot can take a new record if it is empty or being emptied now.
    logic free;
    assign free = !valid || ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid      <= 1'b0;
            rec        <= '0;
            lost_count <= '0;
        end else begin
            if (push && free) begin
                rec   <= push_rec;
                valid <= 1'b1;
            end else if (ready) begin
                valid <= 1'b0;
            end

            if (push && !free && (lost_count != {LOST_W{1'b1}}))
                lost_count <= lost_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/filter_peak_detector.sv
//==============================================================================
// Module      : filter_peak_detector
// Description : Threshold-crossing pulse detector on the shaped filter output.
//               Measures peak amplitude, peak timestamp and pulse width and
//               emits one record per pulse through a single-entry buffer.
// Option      : FILTER_PEAK_DETECTOR_PILEUP_EN - enables pile-up detection
//               (second maximum inside a pulse); otherwise event_pileup = 0.
// Ports       : clk, reset        - clock, async active-high reset
//               input_data        - signed filter sample, one per clk
//               threshold         - signed trigger level
//               event_valid/ready - record handshake
//               event_amp/time/width/truncated/pileup - record fields
//               lost_count        - saturating dropped-event count
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module filter_peak_detector
    import package_settings::*;
#(
    parameter int DATA_W    = SIZE_FILTER_DATA,
    parameter int TS_W      = SIZE_TIMESTAMP,
    parameter int WIDTH_W   = SIZE_PULSE_WIDTH,
    parameter int MAX_WIDTH = 255,
    parameter int LOST_W    = SIZE_LOST_CNT
`ifdef FILTER_PEAK_DETECTOR_PILEUP_EN
    ,
    parameter int PILEUP_HYST = 16
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] input_data,
    input  logic signed [DATA_W-1:0] threshold,
    output logic                     event_valid,
    input  logic                     event_ready,
    output logic signed [DATA_W-1:0] event_amp,
    output logic [TS_W-1:0]          event_time,
    output logic [WIDTH_W-1:0]       event_width,
    output logic                     event_truncated,
    output logic                     event_pileup,
    output logic [LOST_W-1:0]        lost_count
);

    localparam int                 REC_W       = DATA_W + TS_W + WIDTH_W + 2;
    localparam logic [WIDTH_W-1:0] MAX_WIDTH_V = WIDTH_W'(MAX_WIDTH);

    pd_state_t                state, state_next;
    logic [TS_W-1:0]          ts;
    logic signed [DATA_W-1:0] max_val, max_next;
    logic [TS_W-1:0]          peak_ts, peak_ts_next;
    logic [WIDTH_W-1:0]       width, width_next;
    logic                     pileup, pileup_next;
    logic                     pileup_set;
    logic                     above;
    logic                     emit;
    logic                     emit_trunc;
    logic [REC_W-1:0]         emit_rec;
    logic [REC_W-1:0]         buf_rec;

    assign above = input_data > threshold;

`ifdef FILTER_PEAK_DETECTOR_PILEUP_EN
    // Pile-up: the pulse has dropped clearly below its running maximum and
    // then turns upward again.
    logic                     fell;
    logic signed [DATA_W-1:0] prev_sample;
    logic signed [DATA_W:0]   fall_level;

    // One extra bit so max - hysteresis cannot wrap for very negative maxima.
    assign fall_level = $signed({max_val[DATA_W-1], max_val})
                      - $signed((DATA_W+1)'(PILEUP_HYST));
    assign pileup_set = fell && (input_data > prev_sample);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fell        <= 1'b0;
            prev_sample <= '0;
        end else begin
            prev_sample <= input_data;
            if (state == PD_PULSE && above)
                fell <= fell | ($signed({input_data[DATA_W-1], input_data}) < fall_level);
            else
                fell <= 1'b0;
        end
    end
`else
    assign pileup_set = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= PD_IDLE;
            ts      <= '0;
            max_val <= '0;
            peak_ts <= '0;
            width   <= '0;
            pileup  <= 1'b0;
        end else begin
            state   <= state_next;
            ts      <= ts + 1'b1;
            max_val <= max_next;
            peak_ts <= peak_ts_next;
            width   <= width_next;
            pileup  <= pileup_next;
        end
    end

    always_comb begin
        state_next   = state;
        max_next     = max_val;
        peak_ts_next = peak_ts;
        width_next   = width;
        pileup_next  = pileup;
        emit         = 1'b0;
        emit_trunc   = 1'b0;

        case (state)
            PD_IDLE: begin
                if (above) begin
                    state_next   = PD_PULSE;
                    max_next     = input_data;
                    peak_ts_next = ts;
                    width_next   = {{(WIDTH_W-1){1'b0}}, 1'b1};
                    pileup_next  = 1'b0;
                end
            end
            PD_PULSE: begin
                if (above) begin
                    width_next = width + 1'b1;
                    // Strict compare: on a plateau the first sample keeps the peak.
                    if (input_data > max_val) begin
                        max_next     = input_data;
                        peak_ts_next = ts;
                    end
                    if (pileup_set)
                        pileup_next = 1'b1;
                    if (width_next >= MAX_WIDTH_V) begin
                        emit       = 1'b1;
                        emit_trunc = 1'b1;
                        state_next = PD_WAIT_LOW;
                    end
                end else begin
                    // Terminating sample is not part of the pulse.
                    emit       = 1'b1;
                    state_next = PD_IDLE;
                end
            end
            PD_WAIT_LOW: begin
                if (!above)
                    state_next = PD_IDLE;
            end
            default: state_next = PD_IDLE;
        endcase
    end

    // On a normal end the *_next values equal the registers, so one packing
    // serves both the truncating and the falling-edge emit.
    assign emit_rec = {max_next, peak_ts_next, width_next, emit_trunc, pileup_next};

    pd_event_buffer #(
        .REC_W  (REC_W),
        .LOST_W (LOST_W)
    ) u_event_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (emit),
        .push_rec   (emit_rec),
        .ready      (event_ready),
        .valid      (event_valid),
        .rec        (buf_rec),
        .lost_count (lost_count)
    );

    assign {event_amp, event_time, event_width, event_truncated, event_pileup} = buf_rec;

endmodule

`default_nettype wire

// File: tb/tb_filter_peak_detector.sv
//==============================================================================
// Module      : tb_filter_peak_detector
// Description : Scoreboard bench for filter_peak_detector. Pulses are collected
//               as sample lists and summarised when they end; a monitor
//               compares every accepted record against the expected queue.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_filter_peak_detector;
    import package_settings::*;

    localparam int MAXW = 4;
    localparam int HYST = 16;
`ifdef FILTER_PEAK_DETECTOR_PILEUP_EN
    localparam bit PILEUP_ON = 1'b1;
`else
    localparam bit PILEUP_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [15:0] input_data = '0;
    logic signed [15:0] threshold = 16'sd100;
    logic               event_valid;
    logic               event_ready = 1'b0;
    logic signed [15:0] event_amp;
    logic [31:0]        event_time;
    logic [7:0]         event_width;
    logic               event_truncated;
    logic               event_pileup;
    logic [15:0]        lost_count;

    int tests = 0;
    int fails = 0;

    // Reference model state
    pd_event_t   exp_q[$];
    int          pulse_s[$];
    logic [31:0] pulse_t[$];
    bit          waiting;
    bit          occ;
    int          m_lost;
    logic [31:0] m_ts;

    always #5 clk = ~clk;

    filter_peak_detector #(
        .MAX_WIDTH (MAXW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .input_data      (input_data),
        .threshold       (threshold),
        .event_valid     (event_valid),
        .event_ready     (event_ready),
        .event_amp       (event_amp),
        .event_time      (event_time),
        .event_width     (event_width),
        .event_truncated (event_truncated),
        .event_pileup    (event_pileup),
        .lost_count      (lost_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Summarise a finished pulse from its list of samples.
    function automatic pd_event_t summarize(bit trunc);
        pd_event_t e;
        int  mx   = pulse_s[0];
        int  idx  = 0;
        bit  fell = 1'b0;
        bit  pile = 1'b0;
        for (int j = 1; j < pulse_s.size(); j++) begin
            if (PILEUP_ON && fell && (pulse_s[j] > pulse_s[j-1])) pile = 1'b1;
            if (pulse_s[j] < mx - HYST) fell = 1'b1;
            if (pulse_s[j] > mx) begin
                mx  = pulse_s[j];
                idx = j;
            end
        end
        e.amp       = 16'(mx);
        e.peak_time = pulse_t[idx];
        e.width     = 8'(pulse_s.size());
        e.truncated = trunc;
        e.pileup    = pile;
        return e;
    endfunction

    // What happens at the next clock edge given the sample, threshold and ready.
    task automatic model_step(input int s, input int thr, input bit r);
        bit        emit  = 1'b0;
        bit        above = s > thr;
        pd_event_t e     = '0;
        if (waiting) begin
            if (!above) waiting = 1'b0;
        end else if (pulse_s.size() == 0) begin
            if (above) begin
                pulse_s.push_back(s);
                pulse_t.push_back(m_ts);
            end
        end else if (above) begin
            pulse_s.push_back(s);
            pulse_t.push_back(m_ts);
            if (pulse_s.size() == MAXW) begin
                e = summarize(1'b1);
                emit = 1'b1;
                pulse_s.delete();
                pulse_t.delete();
                waiting = 1'b1;
            end
        end else begin
            e = summarize(1'b0);
            emit = 1'b1;
            pulse_s.delete();
            pulse_t.delete();
        end
        if (emit) begin
            if (!occ || r) begin
                exp_q.push_back(e);
                occ = 1'b1;
            end else if (m_lost < 65535) begin
                m_lost++;
            end
        end else if (occ && r) begin
            occ = 1'b0;
        end
        m_ts = m_ts + 32'd1;
    endtask

    task automatic drive(input int s, input int thr, input bit r);
        @(posedge clk);
        #1;
        chk("event_valid", 64'(event_valid), 64'(occ));
        chk("lost_count", 64'(lost_count), 64'(m_lost));
        #1;
        input_data  = 16'(s);
        threshold   = 16'(thr);
        event_ready = r;
        model_step(s, thr, r);
    endtask

    task automatic seq(input int thr, input bit r, input int vals[$]);
        foreach (vals[i]) drive(vals[i], thr, r);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        input_data  = '0;
        event_ready = 1'b0;
        pulse_s.delete();
        pulse_t.delete();
        exp_q.delete();
        waiting = 1'b0;
        occ     = 1'b0;
        m_lost  = 0;
        m_ts    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(event_valid), 64'(0));
        chk("rst_amp", 64'(event_amp), 64'(0));
        chk("rst_time", 64'(event_time), 64'(0));
        chk("rst_width", 64'(event_width), 64'(0));
        chk("rst_trunc", 64'(event_truncated), 64'(0));
        chk("rst_pileup", 64'(event_pileup), 64'(0));
        chk("rst_lost", 64'(lost_count), 64'(0));
        #1;
        reset = 1'b0;
        model_step(0, int'(threshold), 1'b0);
    endtask

    // Monitor: every accepted record must match the oldest expected one.
    initial begin : monitor
        pd_event_t act;
        pd_event_t e;
        forever begin
            @(negedge clk);
            if (!reset && event_valid && event_ready) begin
                act = {event_amp, event_time, event_width, event_truncated, event_pileup};
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL event_unexpected: got %h, no event expected", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        fails++;
                        $display("FAIL event_record: got amp=%0d t=%0d w=%0d tr=%0b pu=%0b expected amp=%0d t=%0d w=%0d tr=%0b pu=%0b",
                                 act.amp, act.peak_time, act.width, act.truncated, act.pileup,
                                 e.amp, e.peak_time, e.width, e.truncated, e.pileup);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int thr;
        int len;
        int cyc;
        do_reset();

        // Basic pulse: peak 300 lands on ts=10.
        seq(100, 1'b1, '{0, 0, 0, 0, 0, 0});
        seq(100, 1'b1, '{0, 50, 150, 300, 200, 80, 0, 0, 0});
        // Plateau: first 250 keeps the timestamp.
        seq(100, 1'b1, '{0, 200, 250, 250, 0, 0, 0});
        // Pile-up shape.
        seq(100, 1'b1, '{0, 200, 150, 180, 50, 0, 0});
        // Truncation at MAXW, tail ignored.
        seq(0, 1'b1, '{10, 10, 10, 10, 10, 10, 10, 0, 0, 0});
        // Backpressure: first record held, next two dropped, then drained.
        seq(100, 1'b0, '{200, 0, 200, 0, 200, 0, 0, 0});
        seq(100, 1'b1, '{0, 0});
        // Handshake coinciding with a new emit.
        seq(100, 1'b0, '{200, 0, 0, 300});
        seq(100, 1'b1, '{0, 0, 0});

        // Reset in the middle of a pulse, then basic pulse from a fresh ts.
        seq(100, 1'b1, '{0, 50, 150, 300});
        do_reset();
        seq(100, 1'b1, '{0, 0, 0, 0, 0, 0});
        seq(100, 1'b1, '{0, 50, 150, 300, 200, 80, 0, 0, 0});

        // Randomised pulse trains with random backpressure.
        cyc = 0;
        thr = 100;
        while (cyc < 3000) begin
            if (cyc > 1500) thr = -50;
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++)
                drive(thr + 1 + int'($urandom_range(0, 300)), thr, ($urandom_range(0, 3) != 0));
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++)
                drive(thr - int'($urandom_range(0, 200)), thr, ($urandom_range(0, 3) != 0));
            cyc += 10;
        end

        // Drain and confirm nothing is left outstanding.
        for (int i = 0; i < 10; i++) drive(thr - 1, thr, 1'b1);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
